register_1: RTL and testbench

REGISTER_1 -- requirements
Module: register_1

---
 rtl/register_1.sv | 93 +++++++++
 tb/tb_register_1.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/register_1.sv
// ---------------------------------------------------------------------------
// register_1 -- 32-entry general-purpose register file (MIPS style)
//
// Three combinational read ports and one synchronous write port.
// Register 0 is hard-wired to zero: writes to it are dropped and any read of
// address 0 returns 0.
//
// Optional build macro:
//   RF_BYPASS_EN  when defined, a read port whose address matches an active
//                 write (we3=1, wa3!=0, rst=0) returns wd3 combinationally
//                 (write-through forwarding). When undefined, reads show the
//                 stored value until the write edge.
//
// Parameters:
//   DATA_W   register/data width in bits (default 32)
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset; clears every register, and wins
//            over a write in the same cycle
//   we3      write enable
//   wa3      write address (0..31)
//   wd3      write data
//   ra1..3   read addresses
//   rd1..3   read data (combinational)
// ---------------------------------------------------------------------------
module register_1 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we3,
    input  logic [4:0]        wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    input  logic [4:0]        ra3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rd3
);

    localparam int NUM_REGS = 32;

    // Storage. Entry 0 is cleared on reset and never written; the read mux
    // also forces address 0 to zero, so its contents never matter.
    logic [DATA_W-1:0] regs_reg [NUM_REGS];

    // A single write port gated off for address 0. Reset has priority, so a
    // write presented together with rst is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (we3 && (wa3 != 5'd0)) begin
            regs_reg[wa3] <= wd3;
        end
    end

    // Three identical, independent read ports.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rd_port
            logic [4:0]        ra_sel;
            logic [DATA_W-1:0] rd_val;

            assign ra_sel = (gi == 0) ? ra1 :
                            (gi == 1) ? ra2 : ra3;

            always_comb begin
                rd_val = '0;
                if (ra_sel != 5'd0) begin
`ifdef RF_BYPASS_EN
                    // Forward the in-flight write so the reader sees it in
                    // the same cycle it is presented.
                    if (we3 && !rst && (wa3 == ra_sel)) begin
                        rd_val = wd3;
                    end else begin
                        rd_val = regs_reg[ra_sel];
                    end
`else
                    rd_val = regs_reg[ra_sel];
`endif
                end
            end
        end
    endgenerate

    assign rd1 = g_rd_port[0].rd_val;
    assign rd2 = g_rd_port[1].rd_val;
    assign rd3 = g_rd_port[2].rd_val;

endmodule

// File: tb/tb_register_1.sv
// ---------------------------------------------------------------------------
// tb_register_1 -- directed self-checking bench for register_1.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later,
// well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_register_1;

    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              we3;
    logic [4:0]        wa3;
    logic [DATA_W-1:0] wd3;
    logic [4:0]        ra1;
    logic [4:0]        ra2;
    logic [4:0]        ra3;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] rd3;

    int check_count;
    int pass_count;

    register_1 #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .we3 (we3),
        .wa3 (wa3),
        .wd3 (wd3),
        .ra1 (ra1),
        .ra2 (ra2),
        .ra3 (ra3),
        .rd1 (rd1),
        .rd2 (rd2),
        .rd3 (rd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag,
                            input logic [DATA_W-1:0] obs,
                            input logic [DATA_W-1:0] exp_val);
        check_count++;
        if (obs === exp_val) begin
            pass_count++;
            $display("ok   %-14s got=%08h exp=%08h", tag, obs, exp_val);
        end else begin
            $display("FAIL %-14s got=%08h exp=%08h", tag, obs, exp_val);
        end
    endtask

    // Advance past the next rising edge and leave 1 ns of margin.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [DATA_W-1:0] data);
        we3 = 1'b1;
        wa3 = addr;
        wd3 = data;
        tick();
        we3 = 1'b0;
    endtask

    logic [DATA_W-1:0] exp_bypass;
    logic [DATA_W-1:0] pattern;

    initial begin
        check_count = 0;
        pass_count  = 0;
        rst = 1'b0;
        we3 = 1'b0;
        wa3 = '0;
        wd3 = '0;
        ra1 = '0;
        ra2 = '0;
        ra3 = '0;

        // Reset for one edge, then read assorted addresses.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ra1 = 5'd5; ra2 = 5'd31; ra3 = 5'd1;
        #1;
        check_eq("rst_rd1", rd1, 32'h0);
        check_eq("rst_rd2", rd2, 32'h0);
        check_eq("rst_rd3", rd3, 32'h0);

        // Basic write/read.
        write_reg(5'd1, 32'd10);
        ra1 = 5'd1;
        #1;
        check_eq("wr_r1", rd1, 32'd10);

        // Writes to register 0 are discarded.
        write_reg(5'd0, 32'hFFFF_FFFF);
        ra1 = 5'd0; ra2 = 5'd0; ra3 = 5'd0;
        #1;
        check_eq("r0_rd1", rd1, 32'h0);
        check_eq("r0_rd2", rd2, 32'h0);
        check_eq("r0_rd3", rd3, 32'h0);

        // Triple read, distinct then identical addresses.
        write_reg(5'd2, 32'hA5A5_A5A5);
        write_reg(5'd3, 32'h1234_5678);
        write_reg(5'd4, 32'd7);
        ra1 = 5'd2; ra2 = 5'd3; ra3 = 5'd4;
        #1;
        check_eq("tri_rd1", rd1, 32'hA5A5_A5A5);
        check_eq("tri_rd2", rd2, 32'h1234_5678);
        check_eq("tri_rd3", rd3, 32'd7);
        ra1 = 5'd3; ra2 = 5'd3; ra3 = 5'd3;
        #1;
        check_eq("same_rd1", rd1, 32'h1234_5678);
        check_eq("same_rd2", rd2, 32'h1234_5678);
        check_eq("same_rd3", rd3, 32'h1234_5678);

        // Reset beats a coinciding write; mid-run reset clears everything.
        ra1 = 5'd1;
        #1;
        check_eq("pre_rst_r1", rd1, 32'd10);
        rst = 1'b1; we3 = 1'b1; wa3 = 5'd1; wd3 = 32'd99;
        tick();
        rst = 1'b0; we3 = 1'b0;
        ra1 = 5'd1; ra2 = 5'd2; ra3 = 5'd4;
        #1;
        check_eq("rstpri_r1", rd1, 32'h0);
        check_eq("rstclr_r2", rd2, 32'h0);
        check_eq("rstclr_r4", rd3, 32'h0);

        // Bypass behaviour before the edge, then committed value after.
        write_reg(5'd6, 32'd5);
        we3 = 1'b1; wa3 = 5'd6; wd3 = 32'd9;
        ra1 = 5'd6; ra2 = 5'd0; ra3 = 5'd7;
`ifdef RF_BYPASS_EN
        exp_bypass = 32'd9;
`else
        exp_bypass = 32'd5;
`endif
        #1;
        check_eq("byp_pre_r6", rd1, exp_bypass);
        check_eq("byp_r0", rd2, 32'h0);
        check_eq("byp_other", rd3, 32'h0);
        tick();
        we3 = 1'b0;
        #1;
        check_eq("byp_post_r6", rd1, 32'd9);

        // we3=0 leaves contents unchanged.
        wa3 = 5'd6; wd3 = 32'd77;
        tick();
        check_eq("nowe_r6", rd1, 32'd9);

        // Write every register with a distinct pattern, read back all 32.
        for (int i = 1; i < 32; i++) begin
            pattern = 32'hC000_0000 | (i * 32'h0001_0003);
            write_reg(5'(i), pattern);
        end
        for (int i = 0; i < 32; i++) begin
            pattern = (i == 0) ? 32'h0 : (32'hC000_0000 | (i * 32'h0001_0003));
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            ra3 = 5'(i);
            #1;
            check_eq($sformatf("sweep_r%0d", i), rd1, pattern);
            check_eq($sformatf("sweep3_r%0d", i), rd3, pattern);
        end
        ra2 = 5'd31;
        #1;
        check_eq("sweep_r31_p2", rd2, 32'hC000_0000 | (31 * 32'h0001_0003));

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
